// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV64M execute-stage controller.
package muldiv_pkg;

   localparam int XLEN = 64;

   typedef enum logic [3:0] {
      MUL   = 4'd0,
      MULW  = 4'd1,
      DIV   = 4'd2,
      DIVU  = 4'd3,
      REM   = 4'd4,
      REMU  = 4'd5,
      DIVW  = 4'd6,
      DIVUW = 4'd7,
      REMW  = 4'd8,
      REMUW = 4'd9
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_DIV_WAIT = 2'd2,
      ST_DONE     = 2'd3
   } md_state_t;

   localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
   localparam logic [31:0] INT32_MIN = 32'h8000_0000;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic op_legal(input logic [3:0] op);
      return op <= 4'd9;
   endfunction

   function automatic logic op_is_mul(input logic [3:0] op);
      return (op == MUL) || (op == MULW);
   endfunction

   function automatic logic op_is_w(input logic [3:0] op);
      return (op == MULW) || (op == DIVW) || (op == DIVUW) || (op == REMW) || (op == REMUW);
   endfunction

   function automatic logic op_is_signed(input logic [3:0] op);
      return (op == DIV) || (op == REM) || (op == DIVW) || (op == REMW);
   endfunction

   function automatic logic op_is_rem(input logic [3:0] op);
      return (op == REM) || (op == REMU) || (op == REMW) || (op == REMUW);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_sign_fix.sv
// Divider operand conditioning (width/sign extension, magnitudes, special cases)
// and signed result correction. Purely combinational.
module div_sign_fix
   import muldiv_pkg::*;
(
   input  logic [3:0]      i_op,
   input  logic [XLEN-1:0] i_src1,
   input  logic [XLEN-1:0] i_src2,
   output logic [XLEN-1:0] o_a_mag,
   output logic [XLEN-1:0] o_b_mag,
   output logic            o_neg_q,
   output logic            o_neg_r,
   output logic            o_special,
   output logic [XLEN-1:0] o_special_res,
   input  logic            i_neg_q,
   input  logic            i_neg_r,
   input  logic            i_is_rem,
   input  logic            i_is_w,
   input  logic [XLEN-1:0] i_q,
   input  logic [XLEN-1:0] i_r,
   output logic [XLEN-1:0] o_res
);

   logic            w_is_w, w_sgn, w_rem;
   logic [XLEN-1:0] w_a_ext, w_b_ext;
   logic            w_a_neg, w_b_neg, w_div0, w_ovf;
   logic [XLEN-1:0] w_q_s, w_r_s, w_v;

   always_comb begin
      w_is_w  = op_is_w(i_op);
      w_sgn   = op_is_signed(i_op);
      w_rem   = op_is_rem(i_op);
      w_a_ext = i_src1;
      w_b_ext = i_src2;
      if (w_is_w) begin
         w_a_ext = w_sgn ? sext32(i_src1[31:0]) : {32'b0, i_src1[31:0]};
         w_b_ext = w_sgn ? sext32(i_src2[31:0]) : {32'b0, i_src2[31:0]};
      end
      w_a_neg = w_sgn & w_a_ext[XLEN-1];
      w_b_neg = w_sgn & w_b_ext[XLEN-1];
      o_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
      o_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
      o_neg_q = w_a_neg ^ w_b_neg;
      o_neg_r = w_a_neg;

      // MIN / -1: the extended dividend already is the architectural quotient.
      w_div0 = (w_b_ext == '0);
      w_ovf  = w_sgn && (&w_b_ext) &&
               (w_a_ext == (w_is_w ? sext32(INT32_MIN) : INT64_MIN));

      o_special     = 1'b0;
      o_special_res = '0;
      if (!op_legal(i_op)) begin
         o_special = 1'b1;
      end else if (!op_is_mul(i_op) && w_div0) begin
         o_special     = 1'b1;
         o_special_res = !w_rem ? '1 : (w_is_w ? sext32(i_src1[31:0]) : i_src1);
      end else if (!op_is_mul(i_op) && w_ovf) begin
         o_special     = 1'b1;
         o_special_res = w_rem ? '0 : w_a_ext;
      end
   end

   always_comb begin
      w_q_s = i_neg_q ? -i_q : i_q;
      w_r_s = i_neg_r ? -i_r : i_r;
      w_v   = i_is_rem ? w_r_s : w_q_s;
      o_res = i_is_w ? sext32(w_v[31:0]) : w_v;
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV64M execute-stage controller: issues one op to the external multiplier or
// divider, waits for its done pulse, fixes up the result and hands it to EX/MEM.
//
// state        | meaning
// ST_IDLE      | ready for a new op (in_ready=1)
// ST_MUL_WAIT  | mul_valid held, waiting for mul_ok
// ST_DIV_WAIT  | div_valid held, waiting for div_ok
// ST_DONE      | out_valid held with stable out_data until out_ready
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  md_op_t          op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            mul_valid,
   output logic [XLEN-1:0] mul_a,
   output logic [XLEN-1:0] mul_b,
   input  logic            mul_ok,
   input  logic [XLEN-1:0] mul_c,
   output logic            div_valid,
   output logic [XLEN-1:0] div_a,
   output logic [XLEN-1:0] div_b,
   input  logic            div_ok,
   input  logic [XLEN-1:0] div_q,
   input  logic [XLEN-1:0] div_r
);

   md_state_t       r_state, w_next;
   logic [XLEN-1:0] r_opa, r_opb, r_out_data;
   logic            r_is_w, r_is_rem, r_neg_q, r_neg_r;

   logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res, w_div_res;
   logic            w_neg_q, w_neg_r, w_special, w_is_mul, w_accept;

   div_sign_fix u_sign_fix (
      .i_op          (op),
      .i_src1        (src1),
      .i_src2        (src2),
      .o_a_mag       (w_a_mag),
      .o_b_mag       (w_b_mag),
      .o_neg_q       (w_neg_q),
      .o_neg_r       (w_neg_r),
      .o_special     (w_special),
      .o_special_res (w_special_res),
      .i_neg_q       (r_neg_q),
      .i_neg_r       (r_neg_r),
      .i_is_rem      (r_is_rem),
      .i_is_w        (r_is_w),
      .i_q           (div_q),
      .i_r           (div_r),
      .o_res         (w_div_res)
   );

   assign w_is_mul = op_is_mul(op);
   assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // flush outranks ok and out_ready.
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:
               if (in_valid) begin
                  if (w_special)     w_next = ST_DONE;
                  else if (w_is_mul) w_next = ST_MUL_WAIT;
                  else               w_next = ST_DIV_WAIT;
               end
            ST_MUL_WAIT: if (mul_ok)    w_next = ST_DONE;
            ST_DIV_WAIT: if (div_ok)    w_next = ST_DONE;
            ST_DONE:     if (out_ready) w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
      mul_valid = (r_state == ST_MUL_WAIT);
      div_valid = (r_state == ST_DIV_WAIT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_opa      <= '0;
         r_opb      <= '0;
         r_is_w     <= 1'b0;
         r_is_rem   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_out_data <= '0;
      end else if (w_accept) begin
         r_opa    <= w_is_mul ? src1 : w_a_mag;
         r_opb    <= w_is_mul ? src2 : w_b_mag;
         r_is_w   <= op_is_w(op);
         r_is_rem <= op_is_rem(op);
         r_neg_q  <= w_neg_q;
         r_neg_r  <= w_neg_r;
         if (w_special) r_out_data <= w_special_res;
      end else if ((r_state == ST_MUL_WAIT) && mul_ok && !flush) begin
         r_out_data <= r_is_w ? sext32(mul_c[31:0]) : mul_c;
      end else if ((r_state == ST_DIV_WAIT) && div_ok && !flush) begin
         r_out_data <= w_div_res;
      end
   end

   assign out_data = r_out_data;
   assign mul_a    = r_opa;
   assign mul_b    = r_opb;
   assign div_a    = r_opa;
   assign div_b    = r_opb;

endmodule
